ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, 8, RAM address width; DWIDTH, 16, RAM data width; STARVE_LIMIT, 8, host wait cycles before a forced slot (legal range 2..255).
REQ-002 Ports SHALL be, clock and reset first: clk in 1 clock; rst in 1 reset.
REQ-003 Reset rst SHALL be synchronous and active-high; clock clk; all state updates SHALL occur on the rising edge of clk.
REQ-004 CPU side SHALL be: cpu_rd in 1; cpu_wr in 1; cpu_raddr in AWIDTH; cpu_waddr in AWIDTH; cpu_wdata in DWIDTH; cpu_rdata out DWIDTH; cpu_stall out 1, meaning the CPU holds and repeats its access next cycle.
REQ-005 Host side SHALL be: host_req in 1; host_we in 1, 1=write; host_addr in AWIDTH; host_wdata in DWIDTH; host_gnt out 1, meaning the access is issued this cycle; host_rvalid out 1; host_rdata out DWIDTH.
REQ-006 RAM side SHALL be: ram_rd out 1; ram_wr out 1; ram_raddr out AWIDTH; ram_waddr out AWIDTH; ram_wdata out DWIDTH; ram_rdata in DWIDTH, valid one cycle after ram_rd.

Function
REQ-007 FSM states SHALL be IDLE, FORCE and RD_RESP.
REQ-008 A host slot SHALL be free when state is IDLE and the CPU strobe on the matching port is low: cpu_rd=0 for a host read, cpu_wr=0 for a host write.
REQ-009 In IDLE, host_gnt SHALL be combinational: host_req AND slot free.
REQ-010 On a granted host write, ram_wr=1, ram_waddr=host_addr and ram_wdata=host_wdata SHALL be driven the same cycle; next state SHALL be IDLE.
REQ-011 On a granted host read, ram_rd=1 and ram_raddr=host_addr SHALL be driven the same cycle; next state SHALL be RD_RESP.
REQ-012 In RD_RESP, host_rvalid=1 and host_rdata=ram_rdata SHALL be driven for exactly one cycle; host_gnt SHALL be 0; next state SHALL be IDLE. Host read throughput is therefore at most one read per 2 cycles.
REQ-013 When not granted, all CPU strobes, addresses and data SHALL pass straight to the RAM ports; cpu_rdata SHALL equal ram_rdata at all times.
REQ-014 The CPU port not used by the host SHALL pass through in the same cycle; a host read and a CPU write may coexist, as may a host write and a CPU read.
REQ-015 Starve counter (8 bit) SHALL increment each IDLE cycle with host_req=1 and host_gnt=0. It SHALL clear on grant, when host_req=0, and in FORCE.
REQ-016 When the counter equals STARVE_LIMIT-1 and the host is again not granted, next state SHALL be FORCE.
REQ-017 In FORCE: cpu_stall=1 and host_gnt=1; the host access SHALL be driven per REQ-010/011; CPU strobes on the host-used port SHALL be masked to 0. Next state SHALL be RD_RESP for a read, else IDLE.
REQ-018 cpu_stall SHALL be 1 only in FORCE, for exactly one cycle per starvation event.
REQ-019 The host SHALL hold host_we, host_addr and host_wdata stable while host_req=1 and host_gnt=0. If host_req drops before grant, no access SHALL be issued.
REQ-020 host_req SHALL be ignored in RD_RESP: no grant, no counting.
REQ-021 The counter SHALL never wrap; it saturates at STARVE_LIMIT-1 by construction.

Reset
REQ-022 While rst=1, the next state SHALL be IDLE and the counter SHALL be 0.
REQ-023 Registered outputs after reset SHALL be cpu_stall=0 and host_rvalid=0. Combinational outputs SHALL follow REQ-009/013: host_gnt=0 when host_req=0; ram_* equal the cpu_* inputs; host_rdata=ram_rdata.
REQ-024 Reset in RD_RESP or FORCE SHALL abort the transaction: no host_rvalid, and no cpu_stall in the following cycle.

Verification
REQ-025 Idle CPU, host write addr 0x10 data 0xBEEF -> host_gnt=1 the same cycle, ram_wr=1, ram_waddr=0x10; a later host read of 0x10 -> host_rvalid=1 with 0xBEEF one cycle after grant.
REQ-026 cpu_rd=1 continuously, host read 0x20 -> no grant for 7 cycles; cycle 8: cpu_stall=1, host_gnt=1, ram_raddr=0x20; cycle 9: host_rvalid=1, cpu_stall=0.
REQ-027 Same cycle: cpu_wr to 0x05 data 0x1111 and host read 0x05 -> both issued; host_gnt=1; ram_wr=1 and ram_rd=1 in the same cycle.
REQ-028 Back-to-back host reads with idle CPU -> grants exactly every 2nd cycle; no host_gnt while host_rvalid=1.
REQ-029 rst=1 asserted in the RD_RESP cycle -> host_rvalid=0, state IDLE, counter 0; a following host write is granted immediately.
REQ-030 host_req dropped after 4 starved cycles, then reasserted -> the counter restarts from 0; FORCE is reached only after a further 8 starved cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbitrates a single dual-port RAM between a priority CPU and an opportunistic host.
// The host uses whichever RAM port the CPU leaves idle, and gets a forced slot after starving.
module ram_arbiter #(
    parameter int unsigned AWIDTH       = 8,
    parameter int unsigned DWIDTH       = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_raddr,
    input  logic [AWIDTH-1:0] cpu_waddr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [AWIDTH-1:0] ram_raddr,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StForce, StRdResp} state_e;

    localparam logic [7:0] CntLast = 8'(STARVE_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       stall_q, stall_d;
    logic       rvalid_q, rvalid_d;
    logic       slot_free;
    logic       host_rd_go;
    logic       host_wr_go;

    always_comb begin
        slot_free  = (state_q == StIdle) && (host_we ? !cpu_wr : !cpu_rd);
        host_gnt   = (state_q == StForce) || (host_req && slot_free);
        host_rd_go = host_gnt && !host_we;
        host_wr_go = host_gnt && host_we;

        // The host overrides only the port it uses; the other CPU port passes through.
        ram_rd    = cpu_rd || host_rd_go;
        ram_raddr = host_rd_go ? host_addr : cpu_raddr;
        ram_wr    = cpu_wr || host_wr_go;
        ram_waddr = host_wr_go ? host_addr : cpu_waddr;
        ram_wdata = host_wr_go ? host_wdata : cpu_wdata;

        cpu_rdata   = ram_rdata;
        host_rdata  = ram_rdata;
        cpu_stall   = stall_q;
        host_rvalid = rvalid_q && !rst;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (host_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = host_we ? StIdle : StRdResp;
                end else if (!host_req) begin
                    cnt_d = 8'd0;
                end else begin
                    if (cnt_q < CntLast) cnt_d = cnt_q + 8'd1;
                    if (cnt_d == CntLast) state_d = StForce;
                end
            end
            StForce: begin
                cnt_d   = 8'd0;
                state_d = host_we ? StIdle : StRdResp;
            end
            StRdResp: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (rst) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end
        stall_d  = (state_d == StForce);
        rvalid_d = (state_d == StRdResp);
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        stall_q  <= stall_d;
        rvalid_q <= rvalid_d;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, vector table for the idle-state routing,
// hand sequences for starvation, back-to-back reads and reset aborts.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_raddr, cpu_waddr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic        ram_rd, ram_wr;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [15:0] sb [$];

    typedef struct {
        logic        c_rd, c_wr, h_req, h_we;
        logic        gnt, rd, wr;
        logic [7:0]  raddr, waddr;
        logic [15:0] wdata;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    ram_arbiter #(.AWIDTH(8), .DWIDTH(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous RAM: read data valid the cycle after ram_rd, old data on collision.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (host_rvalid) begin
            chk("gnt_during_rvalid", 32'(host_gnt), 32'd0);
            if (sb.size() == 0) chk("rvalid_unexpected", 32'(host_rvalid), 32'd0);
            else chk("host_rdata", 32'(host_rdata), 32'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_rd = 1'b0; cpu_wr = 1'b0; host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        chk("hw_gnt", 32'(host_gnt), 32'd1);
        chk("hw_waddr", 32'(ram_waddr), 32'(a));
        ref_mem[a] = d;
        tick();
        idle_in();
    endtask

    // Starve a host read of 0x20 behind cpu_rd; returns the cycle index of the grant.
    task automatic starve_read(output int gcyc);
        gcyc = 0;
        for (int c = 1; c <= 20 && gcyc == 0; c++) begin
            @(negedge clk);
            if (host_gnt) begin
                gcyc = c;
                sb.push_back(ref_mem[8'h20]);
                chk("force_stall", 32'(cpu_stall), 32'd1);
                chk("force_ram_rd", 32'(ram_rd), 32'd1);
                chk("force_raddr", 32'(ram_raddr), 32'h20);
            end else begin
                chk("starve_no_stall", 32'(cpu_stall), 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        int gcyc;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        rst = 1'b1; idle_in();
        cpu_rd = 1'b1; cpu_raddr = 8'h44; cpu_waddr = 8'h22; cpu_wdata = 16'hC0DE;
        host_addr = 8'h33; host_wdata = 16'h4444;
        tick(); tick();
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_gnt", 32'(host_gnt), 32'd0);
        chk("rst_ram_rd", 32'(ram_rd), 32'd1);
        chk("rst_ram_raddr", 32'(ram_raddr), 32'h44);
        tick();
        rst = 1'b0; idle_in(); cpu_raddr = 8'h11;

        //          c_rd  c_wr  h_req h_we  gnt   rd    wr    raddr  waddr  wdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 16'hC0DE};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 16'hC0DE};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 8'h33, 16'h4444};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 16'hC0DE};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h33, 16'h4444};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 16'hC0DE};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h22, 16'hC0DE};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h22, 16'hC0DE};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 16'hC0DE};

        for (int i = 0; i < 9; i++) begin
            cpu_rd = vecs[i].c_rd; cpu_wr = vecs[i].c_wr;
            host_req = vecs[i].h_req; host_we = vecs[i].h_we;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 32'(host_gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_rd", i), 32'(ram_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wr", i), 32'(ram_wr), 32'(vecs[i].wr));
            if (vecs[i].rd) chk($sformatf("v%0d_raddr", i), 32'(ram_raddr), 32'(vecs[i].raddr));
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_waddr", i), 32'(ram_waddr), 32'(vecs[i].waddr));
                chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdata));
            end
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'd0);
            if (vecs[i].h_req && vecs[i].gnt && !vecs[i].h_we) sb.push_back(ref_mem[8'h33]);
            if (vecs[i].wr) ref_mem[vecs[i].waddr] = vecs[i].wdata;
            tick();
            idle_in();
            @(negedge clk);
            tick();
        end

        // Host write then read of 0x10 with an idle CPU.
        host_write(8'h10, 16'hBEEF);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        @(negedge clk);
        chk("rd10_gnt", 32'(host_gnt), 32'd1);
        chk("rd10_raddr", 32'(ram_raddr), 32'h10);
        sb.push_back(ref_mem[8'h10]);
        tick();
        idle_in();
        @(negedge clk);
        chk("rd10_rvalid", 32'(host_rvalid), 32'd1);
        tick();

        // Starvation behind a continuous CPU read.
        host_write(8'h20, 16'h2020);
        cpu_rd = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        starve_read(gcyc);
        chk("starve_grant_cycle", 32'(gcyc), 32'd8);
        host_req = 1'b0;
        @(negedge clk);
        chk("starve_rvalid", 32'(host_rvalid), 32'd1);
        chk("starve_stall_clr", 32'(cpu_stall), 32'd0);
        tick();

        // Dropping host_req restarts the starve count.
        host_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("pre_drop_no_gnt", 32'(host_gnt), 32'd0);
            tick();
        end
        host_req = 1'b0;
        @(negedge clk);
        tick();
        host_req = 1'b1;
        starve_read(gcyc);
        chk("restart_grant_cycle", 32'(gcyc), 32'd8);
        idle_in();
        @(negedge clk);
        tick();

        // CPU write and host read of the same address in one cycle.
        cpu_wr = 1'b1; cpu_waddr = 8'h05; cpu_wdata = 16'h1111;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        @(negedge clk);
        chk("mix_gnt", 32'(host_gnt), 32'd1);
        chk("mix_ram_wr", 32'(ram_wr), 32'd1);
        chk("mix_ram_rd", 32'(ram_rd), 32'd1);
        chk("mix_raddr", 32'(ram_raddr), 32'h05);
        chk("mix_waddr", 32'(ram_waddr), 32'h05);
        sb.push_back(ref_mem[8'h05]);
        ref_mem[8'h05] = 16'h1111;
        tick();
        idle_in();
        @(negedge clk);
        tick();

        // Back-to-back host reads: a grant every second cycle.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_gnt%0d", i), 32'(host_gnt), 32'((i % 2) == 0));
            if ((i % 2) == 0) sb.push_back(ref_mem[8'h05]);
            tick();
        end
        idle_in();
        @(negedge clk);
        tick();

        // Reset in RD_RESP aborts the response; the next host write is granted at once.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        @(negedge clk);
        chk("abort_gnt", 32'(host_gnt), 32'd1);
        tick();
        idle_in(); rst = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", 32'(host_rvalid), 32'd0);
        tick();
        rst = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 16'h3030;
        @(negedge clk);
        chk("post_rst_gnt", 32'(host_gnt), 32'd1);
        chk("post_rst_stall", 32'(cpu_stall), 32'd0);
        ref_mem[8'h30] = 16'h3030;
        tick();
        idle_in();

        // Reset in FORCE: no stall and no response in the following cycle.
        cpu_rd = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstforce_stall_in", 32'(cpu_stall), 32'd1);
        tick();
        rst = 1'b0; idle_in();
        @(negedge clk);
        chk("rstforce_stall", 32'(cpu_stall), 32'd0);
        chk("rstforce_rvalid", 32'(host_rvalid), 32'd0);
        tick(); tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
